// File: rtl/wb_timer_irq_pkg.sv
// Shared constants for the Wishbone timer: register indices, CTRL bit positions,
// prescaler width and a byte-lane write-merge helper.
package wb_timer_pkg;

    localparam int PRESCALE_W = 16;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_COUNT    = 3'd1;
    localparam logic [2:0] REG_COMPARE  = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_irq_if.sv
// Wishbone classic slave bus bundle for the timer; the CPU side is the master.
interface wb_timer_irq_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_timer_irq_prescaler.sv
// Tick divider: 16-bit down-counter emitting one tick every div+1 enabled clocks.
module wb_timer_prescaler
    import wb_timer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);
    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= div;
        end else if (en) begin
            if (cnt == '0) cnt <= div;
            else           cnt <= cnt - 1'b1;
        end
    end

    // A reload cycle restarts the period, so it never produces a tick itself.
    assign tick = en & ~load & (cnt == '0);

endmodule

// File: rtl/wb_timer_irq.sv
// Wishbone timer with compare-match interrupt (level irq = PEND & IE).
// Optional tick divider enabled by defining WB_TIMER_PRESCALER_EN.
module wb_timer_irq
    import wb_timer_pkg::*;
#(
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    wb_timer_irq_if.slave wb,
    output logic          irq_o
);
    logic                  ctrl_en, ctrl_ar, ctrl_ie, pend;
    logic [31:0]           count, compare, rd_data, ctrl_word, ctrl_next;
    logic [PRESCALE_W-1:0] prescale;
    logic [2:0]            idx;
    logic                  bus_req, wr, wr_ctrl, wr_count, wr_compare, wr_status;
    logic                  tick, match;
    logic                  unused_bits;

    assign idx        = wb.wb_adr_i[4:2];
    // The ~ack term turns a held strobe into one access per two cycles.
    assign bus_req    = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign wr         = bus_req & wb.wb_we_i;
    assign wr_ctrl    = wr & (idx == REG_CTRL);
    assign wr_count   = wr & (idx == REG_COUNT);
    assign wr_compare = wr & (idx == REG_COMPARE);
    assign wr_status  = wr & (idx == REG_STATUS);

    always_comb begin
        ctrl_word          = '0;
        ctrl_word[CTRL_EN] = ctrl_en;
        ctrl_word[CTRL_AR] = ctrl_ar;
        ctrl_word[CTRL_IE] = ctrl_ie;
    end
    assign ctrl_next = apply_sel(ctrl_word, wb.wb_dat_i, wb.wb_sel_i);

`ifdef WB_TIMER_PRESCALER_EN
    logic                  wr_prescale;
    logic [PRESCALE_W-1:0] prescale_next;

    assign wr_prescale = wr & (idx == REG_PRESCALE);

    always_comb begin
        prescale_next = prescale;
        if (wr_prescale) begin
            if (wb.wb_sel_i[0]) prescale_next[7:0]  = wb.wb_dat_i[7:0];
            if (wb.wb_sel_i[1]) prescale_next[15:8] = wb.wb_dat_i[15:8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) prescale <= '0;
        else       prescale <= prescale_next;
    end

    // The divider reloads from the value being written, not the stale register.
    wb_timer_prescaler u_prescaler (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (ctrl_en),
        .load  (wr_prescale),
        .div   (prescale_next),
        .tick  (tick)
    );
`else
    assign prescale = '0;
    assign tick     = ctrl_en;
`endif

    assign match = tick & ctrl_en & (count == compare) & ~wr_count;

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_CTRL:     rd_data = ctrl_word;
            REG_COUNT:    rd_data = count;
            REG_COMPARE:  rd_data = compare;
            REG_STATUS:   rd_data[0] = pend;
            REG_PRESCALE: rd_data[PRESCALE_W-1:0] = prescale;
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            ctrl_en     <= 1'b0;
            ctrl_ar     <= 1'b0;
            ctrl_ie     <= 1'b0;
            count       <= '0;
            compare     <= RESET_COMPARE;
            pend        <= 1'b0;
        end else begin
            wb.wb_ack_o <= bus_req;
            wb.wb_dat_o <= bus_req ? rd_data : '0;

            if (wr_ctrl) begin
                ctrl_en <= ctrl_next[CTRL_EN];
                ctrl_ar <= ctrl_next[CTRL_AR];
                ctrl_ie <= ctrl_next[CTRL_IE];
            end else if (match && !ctrl_ar) begin
                ctrl_en <= 1'b0;
            end

            if (wr_count) begin
                count <= apply_sel(count, wb.wb_dat_i, wb.wb_sel_i);
            end else if (tick && ctrl_en) begin
                if (count == compare) begin
                    if (ctrl_ar) count <= '0;
                end else begin
                    count <= count + 32'd1;
                end
            end

            if (wr_compare) compare <= apply_sel(compare, wb.wb_dat_i, wb.wb_sel_i);

            if (match)
                pend <= 1'b1;
            else if (wr_status && wb.wb_sel_i[0] && wb.wb_dat_i[0])
                pend <= 1'b0;
        end
    end

    assign irq_o = pend & ctrl_ie;

    assign unused_bits = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0], ctrl_next[31:3]};

endmodule

// File: tb/tb_wb_timer_irq.sv
// Self-checking bench for wb_timer_irq: register vector table, directed timing
// sequences and a randomized run against a closed-form counter model.
module tb_wb_timer_irq;
    import wb_timer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    int   cyc_n = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    wb_timer_irq_if wb ();

    wb_timer_irq #(.RESET_COMPARE(32'hFFFF_FFFF)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (wb),
        .irq_o (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        bit          we;
        logic [2:0]  idx;
        logic [31:0] wdata;
        logic [3:0]  sel;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus access; e_n is the clock edge at which the DUT raised ack.
    task automatic xfer(input bit we, input logic [2:0] idx, input logic [31:0] wdata,
                        input logic [3:0] sel, output logic [31:0] rdata, output int e_n);
        if (wb.wb_ack_o) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        wb.wb_cyc_i = 1'b1;
        wb.wb_stb_i = 1'b1;
        wb.wb_we_i  = we;
        wb.wb_adr_i = ($urandom() & 32'hFFFF_FFE3) | {27'd0, idx, 2'b00};
        wb.wb_dat_i = wdata;
        wb.wb_sel_i = sel;
        @(posedge clk); #1;
        e_n = cyc_n;
        check("ack_latency", {31'd0, wb.wb_ack_o}, 32'd1);
        rdata = wb.wb_dat_o;
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
        wb.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] d, output int e_n);
        logic [31:0] unused_rd;
        xfer(1'b1, idx, d, 4'hF, unused_rd, e_n);
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] d, output int e_n);
        xfer(1'b0, idx, 32'h0, 4'hF, d, e_n);
    endtask

    task automatic wait_edge(input int e);
        for (int i = 0; i < 2000 && cyc_n < e - 1; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Returns the edge at which irq is first seen high, or -1 after the budget.
    task automatic poll_irq(input int budget, output int e_irq);
        e_irq = -1;
        for (int i = 0; i < budget && e_irq < 0; i++) begin
            @(posedge clk); #1;
            if (irq) e_irq = cyc_n;
        end
    endtask

    // Counter state after k ticks from COUNT=s (s <= c), COMPARE=c, EN=1.
    function automatic void model(input int unsigned s, input int unsigned c, input int unsigned k,
                                  input bit ar, output logic [31:0] cnt, output bit pnd, output bit en);
        int unsigned first;
        first = c - s + 1;
        if (k < first) begin
            cnt = s + k; pnd = 1'b0; en = 1'b1;
        end else if (ar) begin
            cnt = (k - first) % (c + 1); pnd = 1'b1; en = 1'b1;
        end else begin
            cnt = c; pnd = 1'b1; en = 1'b0;
        end
    endfunction

    function automatic void add_vec(input bit we, input logic [2:0] idx, input logic [31:0] wdata,
                                    input logic [3:0] sel, input bit chk, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.idx = idx; v.wdata = wdata; v.sel = sel; v.chk = chk; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rdata, exp_cnt;
        int          e, e_w, e_irq, acks, consec;
        bit          prev, pnd, en;
        int unsigned c, s, d, k;
        bit          ar, ie;

        rst = 1'b1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = '0;   wb.wb_dat_i = '0;   wb.wb_sel_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", {31'd0, wb.wb_ack_o}, 32'd0);
        check("reset_dat", wb.wb_dat_o, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        // Register table: reset values, decode, byte lanes, unmapped slots.
        add_vec(0, REG_CTRL,     0, 4'hF, 1, 32'h0);
        add_vec(0, REG_COUNT,    0, 4'hF, 1, 32'h0);
        add_vec(0, REG_COMPARE,  0, 4'hF, 1, 32'hFFFF_FFFF);
        add_vec(0, REG_STATUS,   0, 4'hF, 1, 32'h0);
        add_vec(0, REG_PRESCALE, 0, 4'hF, 1, 32'h0);
        add_vec(0, 3'd5,         0, 4'hF, 1, 32'h0);
        add_vec(1, REG_COMPARE,  32'h0, 4'hF, 0, 32'h0);
        add_vec(1, REG_COMPARE,  32'h0000_00FF, 4'b0001, 0, 32'h0);
        add_vec(0, REG_COMPARE,  0, 4'hF, 1, 32'h0000_00FF);
        add_vec(1, REG_COMPARE,  32'h1234_5678, 4'b1010, 0, 32'h0);
        add_vec(0, REG_COMPARE,  0, 4'hF, 1, 32'h1200_56FF);
        add_vec(1, REG_COUNT,    32'hAABB_CCDD, 4'hF, 0, 32'h0);
        add_vec(0, REG_COUNT,    0, 4'hF, 1, 32'hAABB_CCDD);
        add_vec(1, REG_CTRL,     32'hFFFF_FFF6, 4'hF, 0, 32'h0);
        add_vec(0, REG_CTRL,     0, 4'hF, 1, 32'h6);
        add_vec(1, REG_CTRL,     32'h0, 4'b1110, 0, 32'h0);
        add_vec(0, REG_CTRL,     0, 4'hF, 1, 32'h6);
        add_vec(1, 3'd6,         32'hFFFF_FFFF, 4'hF, 0, 32'h0);
        add_vec(0, 3'd6,         0, 4'hF, 1, 32'h0);
        add_vec(0, 3'd7,         0, 4'hF, 1, 32'h0);
        add_vec(1, REG_PRESCALE, 32'h0001_0005, 4'hF, 0, 32'h0);
`ifdef WB_TIMER_PRESCALER_EN
        add_vec(0, REG_PRESCALE, 0, 4'hF, 1, 32'h5);
`else
        add_vec(0, REG_PRESCALE, 0, 4'hF, 1, 32'h0);
`endif
        add_vec(1, REG_PRESCALE, 32'h0, 4'hF, 0, 32'h0);
        add_vec(1, REG_CTRL,     32'h0, 4'hF, 0, 32'h0);
        add_vec(0, REG_CTRL,     0, 4'hF, 1, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].we, vecs[i].idx, vecs[i].wdata, vecs[i].sel, rdata, e);
            if (vecs[i].chk) check($sformatf("vec%0d", i), rdata, vecs[i].exp);
        end

        // Auto-reload with irq: match on the 10th tick, COUNT back to 0.
        wr(REG_STATUS, 1, e); wr(REG_COUNT, 0, e); wr(REG_COMPARE, 9, e);
        wr(REG_CTRL, 7, e_w);
        poll_irq(40, e_irq);
        check("ar_irq_rise_edge", e_irq, e_w + 10);
        rd(REG_COUNT, rdata, e);
        check("ar_count_after_match", rdata, 32'h0);
        wr(REG_STATUS, 1, e);
        check("w1c_irq_fall", {31'd0, irq}, 32'd0);

        // One-shot: single match, EN self-clears, COUNT holds at COMPARE.
        wr(REG_CTRL, 0, e); wr(REG_STATUS, 1, e); wr(REG_COUNT, 0, e); wr(REG_COMPARE, 3, e);
        wr(REG_CTRL, 5, e_w);
        repeat (10) @(posedge clk);
        #1;
        rd(REG_CTRL, rdata, e);
        check("oneshot_ctrl", rdata, 32'h4);
        rd(REG_COUNT, rdata, e);
        check("oneshot_count", rdata, 32'h3);
        check("oneshot_irq", {31'd0, irq}, 32'd1);

        // 32-bit wrap with no side effect, then match at COUNT=1.
        wr(REG_CTRL, 0, e); wr(REG_STATUS, 1, e); wr(REG_COMPARE, 1, e);
        wr(REG_COUNT, 32'hFFFF_FFFE, e);
        wr(REG_CTRL, 1, e_w);
        for (int i = 0; i < 4; i++) begin
            rd((i % 2 == 0) ? REG_COUNT : REG_STATUS, rdata, e);
            k = e - e_w - 1;
            if (i % 2 == 0)
                check($sformatf("wrap_count_k%0d", k), rdata, (k <= 3) ? 32'hFFFF_FFFE + k : 32'h1);
            else
                check($sformatf("wrap_pend_k%0d", k), rdata, (k >= 4) ? 32'h1 : 32'h0);
        end
        rd(REG_CTRL, rdata, e);
        check("wrap_ctrl_after", rdata, 32'h0);

        // Write-1-clear landing on a match edge: set wins.
        wr(REG_CTRL, 0, e); wr(REG_STATUS, 1, e); wr(REG_COUNT, 0, e); wr(REG_COMPARE, 5, e);
        wr(REG_CTRL, 3, e_w);
        wait_edge(e_w + 12);
        wr(REG_STATUS, 1, e);
        check("w1c_edge", e, e_w + 12);
        rd(REG_STATUS, rdata, e);
        check("w1c_vs_match", rdata, 32'h1);
        wr(REG_CTRL, 0, e);
        wr(REG_STATUS, 0, e);
        rd(REG_STATUS, rdata, e);
        check("status_write0", rdata, 32'h1);
        xfer(1'b1, REG_STATUS, 32'h1, 4'b1110, rdata, e);
        rd(REG_STATUS, rdata, e);
        check("status_sel0_low", rdata, 32'h1);
        wr(REG_STATUS, 1, e);
        rd(REG_STATUS, rdata, e);
        check("status_cleared", rdata, 32'h0);

        // Held strobe: acks are single pulses, one per two cycles.
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = {27'd0, REG_CTRL, 2'b00};
        acks = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (wb.wb_ack_o) acks++;
            if (wb.wb_ack_o && prev) consec++;
            prev = wb.wb_ack_o;
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        check("held_stb_acks", acks, 3);
        check("held_stb_back_to_back", consec, 0);
        @(posedge clk); #1;

        // Randomized runs against the closed-form model.
        for (int it = 0; it < 24; it++) begin
            c  = $urandom_range(0, 15);
            s  = $urandom_range(0, c);
            ar = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            d  = $urandom_range(0, 30);
            wr(REG_CTRL, 0, e); wr(REG_STATUS, 1, e);
            wr(REG_COMPARE, c, e); wr(REG_COUNT, s, e);
            wr(REG_CTRL, {29'd0, ie, ar, 1'b1}, e_w);
            for (int j = 0; j < int'(d); j++) begin
                @(posedge clk); #1;
            end
            if (d > 0) check($sformatf("rnd%0d_idle_dat", it), wb.wb_dat_o, 32'h0);
            rd(REG_COUNT, rdata, e);
            model(s, c, e - e_w - 1, ar, exp_cnt, pnd, en);
            check($sformatf("rnd%0d_count", it), rdata, exp_cnt);
            model(s, c, e - e_w, ar, exp_cnt, pnd, en);
            check($sformatf("rnd%0d_irq", it), {31'd0, irq}, {31'd0, pnd & ie});
            rd(REG_CTRL, rdata, e);
            model(s, c, e - e_w - 1, ar, exp_cnt, pnd, en);
            check($sformatf("rnd%0d_ctrl", it), rdata, {29'd0, ie, ar, en});
            rd(REG_STATUS, rdata, e);
            model(s, c, e - e_w - 1, ar, exp_cnt, pnd, en);
            check($sformatf("rnd%0d_pend", it), rdata, {31'd0, pnd});
        end

        // Reset during a bus cycle aborts it and restores defaults.
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = {27'd0, REG_COUNT, 2'b00};
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_abort_ack", {31'd0, wb.wb_ack_o}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        rst = 1'b0;
        rd(REG_CTRL, rdata, e);
        check("rst_ctrl", rdata, 32'h0);
        rd(REG_COMPARE, rdata, e);
        check("rst_compare", rdata, 32'hFFFF_FFFF);
        rd(REG_COUNT, rdata, e);
        check("rst_count", rdata, 32'h0);

`ifdef WB_TIMER_PRESCALER_EN
        // PRESCALE=3: ticks every 4 clocks, COMPARE=2 matches on the 3rd tick.
        wr(REG_STATUS, 1, e); wr(REG_COUNT, 0, e); wr(REG_COMPARE, 2, e);
        wr(REG_PRESCALE, 3, e);
        wr(REG_CTRL, 7, e_w);
        poll_irq(40, e_irq);
        check("presc_match_edge", e_irq, e_w + 12);

        // Reload mid-period pushes the match out by two clocks.
        wr(REG_CTRL, 0, e); wr(REG_STATUS, 1, e); wr(REG_COUNT, 0, e);
        wr(REG_COMPARE, 1, e); wr(REG_PRESCALE, 3, e);
        wr(REG_CTRL, 7, e_w);
        wait_edge(e_w + 2);
        wr(REG_PRESCALE, 3, e);
        check("presc_reload_edge", e, e_w + 2);
        poll_irq(40, e_irq);
        check("presc_reload_match", e_irq, e_w + 10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
